screen_select_ctrl: RTL and testbench
=====================================

SCREEN_SELECT_CTRL -- requirements
Module: screen_select_ctrl

Interface
REQ-001 SHALL have parameter N_SCR, default 4, meaning the number of screens, legal range 2..4; the screen index is always 2 bits.
REQ-002 SHALL have parameter HOLDOFF, default 16, meaning the number of cycles clicks are ignored after a screen change; must be at least 1.
REQ-003 SHALL have parameters HS_X0, HS_X1, HS_Y0 and HS_Y1, each 12*N_SCR bits, giving the inclusive hotspot bounds of screen i in bits [12i+11:12i]; defaults are screen0 x 500..560, y 320..350 and screen1 x 993..1013, y 10..30; screens 2 and 3 default to X0 > X1 (disabled).
REQ-004 SHALL have parameter HS_TGT, 2*N_SCR bits, giving the target screen of hotspot i in bits [2i+1:2i]; defaults are screen0 -> 1, screen1 -> 0, screens 2 and 3 -> 0.
REQ-005 clk  input  1  single clock; every register is on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 xpos, ypos  input  12 each  pointer coordinates.
REQ-008 ButtonLeft  input  1  level of the left mouse button.
REQ-009 ButtonRight  input  1  level of the right mouse button; used only when SCREEN_CTRL_BACK_EN is defined.
REQ-010 rgb_in  input  12*N_SCR  pixel of screen i in bits [12i+11:12i].
REQ-011 xpos_out, ypos_out  output  12 each  xpos and ypos delayed one cycle.
REQ-012 rgb  output  12  registered pixel of the selected screen.
REQ-013 screen  output  2  current screen index.
REQ-014 changed  output  1  one-cycle pulse on every screen change.

Function
REQ-015 SHALL detect a left click as ButtonLeft=1 with the registered previous ButtonLeft=0; holding the button SHALL produce exactly one click.
REQ-016 SHALL register a hit when HS_X0[s] <= xpos <= HS_X1[s] and HS_Y0[s] <= ypos <= HS_Y1[s] are all true, where s = screen and the comparison uses this cycle's xpos and ypos.
REQ-017 SHALL never register a hit for an entry with X0 > X1 or Y0 > Y1.
REQ-018 SHALL implement state IDLE, in which clicks are accepted.
REQ-019 SHALL implement state HOLD, in which a down-counter runs from HOLDOFF-1 to 0, all clicks are ignored, and the block returns to IDLE on the edge after the counter reaches 0.
REQ-020 On a click with a hit in IDLE, where the target is not screen and the target is less than N_SCR, SHALL on that edge set screen to the target, assert changed, load the counter and enter HOLD.
REQ-021 On a click with a hit where the target equals screen or the target is at least N_SCR, SHALL leave screen unchanged, keep changed at 0 and stay in IDLE.
REQ-022 SHALL register rgb from the rgb_in slice indexed by the next value of screen, so rgb switches on the same edge as screen.
REQ-023 SHALL have no added pixel latency beyond the one output register; xpos_out and ypos_out SHALL have the same one-cycle latency.
REQ-024 SHALL deassert changed on the cycle after it is asserted.
REQ-025 A button still held when HOLD ends SHALL NOT produce a click until it is released and pressed again.

Reset
REQ-026 While rst=1, SHALL hold screen=0, changed=0, state IDLE, counter=0, previous-button registers=0 and history register=0.
REQ-027 While rst=1, rgb SHALL be loaded from the rgb_in slice 0, and xpos_out and ypos_out SHALL keep following their inputs.
REQ-028 A reset asserted during HOLD SHALL abort the holdoff immediately, and the cycle after reset is released SHALL accept clicks.

Configuration
REQ-029 With SCREEN_CTRL_BACK_EN defined, a history register SHALL capture the old screen on every change.
REQ-030 With SCREEN_CTRL_BACK_EN defined, a ButtonRight rising edge in IDLE with history not equal to screen SHALL swap screen and history, pulse changed and enter HOLD.
REQ-031 With SCREEN_CTRL_BACK_EN defined, a left-click change and a right-click back action detected in the same cycle SHALL resolve with the left click winning.
REQ-032 Without SCREEN_CTRL_BACK_EN, ButtonRight SHALL be ignored and no history register SHALL exist.

Verification
REQ-033 After reset, ButtonLeft rises at (530,335) on screen0 -> on the next edge screen=1, changed=1 for one cycle, and rgb equals the rgb_in slice 1.
REQ-034 ButtonLeft rises at (561,335) or (530,351) -> screen stays 0 and changed stays 0; the boundaries (500,320) and (560,350) do hit.
REQ-035 A change is followed by a second click on the screen1 hotspot 5 cycles later with HOLDOFF=16 -> ignored; the same click at least 17 cycles after the change returns the block to screen 0.
REQ-036 ButtonLeft is held at 1 across the whole HOLD period on a hotspot -> no second change.
REQ-037 rst is pulsed mid-HOLD -> screen=0, changed=0, and a click on the cycle after reset is released is accepted.
REQ-038 With SCREEN_CTRL_BACK_EN defined, the sequence 0 -> 1 followed by a ButtonRight edge after the holdoff -> screen=0 and history=1.

Source files
------------

// File: rtl/screen_select_ctrl.sv
// Pointer-driven screen selector: a left click on the current screen's hotspot jumps to its target
// screen, then further clicks are ignored for HOLDOFF cycles. Define SCREEN_CTRL_BACK_EN for right-click "back".
module screen_select_ctrl #(
    parameter int                  N_SCR   = 4,
    parameter int                  HOLDOFF = 16,
    parameter logic [12*N_SCR-1:0] HS_X0   = {12'hFFF, 12'hFFF, 12'd993,  12'd500},
    parameter logic [12*N_SCR-1:0] HS_X1   = {12'h000, 12'h000, 12'd1013, 12'd560},
    parameter logic [12*N_SCR-1:0] HS_Y0   = {12'hFFF, 12'hFFF, 12'd10,   12'd320},
    parameter logic [12*N_SCR-1:0] HS_Y1   = {12'h000, 12'h000, 12'd30,   12'd350},
    parameter logic [2*N_SCR-1:0]  HS_TGT  = {2'd0, 2'd0, 2'd0, 2'd1}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          xpos,
    input  logic [11:0]          ypos,
    input  logic                 ButtonLeft,
    input  logic                 ButtonRight,
    input  logic [12*N_SCR-1:0]  rgb_in,
    output logic [11:0]          xpos_out,
    output logic [11:0]          ypos_out,
    output logic [11:0]          rgb,
    output logic [1:0]           screen,
    output logic                 changed
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]   r_screen;
    logic         r_changed;
    logic         r_btnLPrev;
    logic [11:0]  r_rgb;
    logic [11:0]  r_xpos;
    logic [11:0]  r_ypos;

    logic [11:0]  w_x0, w_x1, w_y0, w_y1;
    logic [1:0]   w_tgt;
    logic         w_hit;
    logic         w_clickL;
    logic         w_goFwd;
    logic         w_goBack;
    logic         w_change;
    logic [1:0]   w_nextScreen;
    logic [11:0]  w_rgbSel;

    // Hotspot and target of the screen currently shown.
    always_comb begin
        w_x0  = '0;
        w_x1  = '0;
        w_y0  = '0;
        w_y1  = '0;
        w_tgt = '0;
        for (int i = 0; i < N_SCR; i++) begin
            if (r_screen == 2'(i)) begin
                w_x0  = HS_X0[12*i +: 12];
                w_x1  = HS_X1[12*i +: 12];
                w_y0  = HS_Y0[12*i +: 12];
                w_y1  = HS_Y1[12*i +: 12];
                w_tgt = HS_TGT[2*i +: 2];
            end
        end
    end

    // An inverted range (X0 > X1 or Y0 > Y1) can never satisfy both bounds, so it never hits.
    assign w_hit    = (xpos >= w_x0) && (xpos <= w_x1) && (ypos >= w_y0) && (ypos <= w_y1);
    assign w_clickL = ButtonLeft && !r_btnLPrev;
    assign w_goFwd  = (r_state == IDLE) && w_clickL && w_hit && (w_tgt != r_screen)
                      && ({1'b0, w_tgt} < 3'(N_SCR));

`ifdef SCREEN_CTRL_BACK_EN
    logic       r_btnRPrev;
    logic [1:0] r_history;

    assign w_goBack     = (r_state == IDLE) && ButtonRight && !r_btnRPrev
                          && (r_history != r_screen) && !w_goFwd;
    assign w_nextScreen = w_goFwd ? w_tgt : (w_goBack ? r_history : r_screen);
`else
    logic w_unused;

    assign w_unused     = ButtonRight;
    assign w_goBack     = 1'b0;
    assign w_nextScreen = w_goFwd ? w_tgt : r_screen;
`endif

    assign w_change = w_goFwd || w_goBack;

    // Pixel source follows the next screen so rgb and screen switch on the same edge.
    always_comb begin
        w_rgbSel = rgb_in[11:0];
        for (int i = 0; i < N_SCR; i++) begin
            if (w_nextScreen == 2'(i)) begin
                w_rgbSel = rgb_in[12*i +: 12];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_screen   <= '0;
            r_changed  <= 1'b0;
            r_btnLPrev <= 1'b0;
            r_rgb      <= rgb_in[11:0];
`ifdef SCREEN_CTRL_BACK_EN
            r_btnRPrev <= 1'b0;
            r_history  <= '0;
`endif
        end else begin
            r_btnLPrev <= ButtonLeft;
            r_screen   <= w_nextScreen;
            r_changed  <= w_change;
            r_rgb      <= w_rgbSel;
`ifdef SCREEN_CTRL_BACK_EN
            r_btnRPrev <= ButtonRight;
            if (w_change) begin
                r_history <= r_screen;
            end
`endif
            case (r_state)
                IDLE: begin
                    if (w_change) begin
                        r_state <= HOLD;
                        r_cnt   <= CW'(HOLDOFF - 1);
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pointer coordinates are a plain one-cycle delay, independent of reset.
    always_ff @(posedge clk) begin
        r_xpos <= xpos;
        r_ypos <= ypos;
    end

    assign xpos_out = r_xpos;
    assign ypos_out = r_ypos;
    assign rgb      = r_rgb;
    assign screen   = r_screen;
    assign changed  = r_changed;

endmodule

// File: tb/tb_screen_select_ctrl.sv
// Scoreboard bench for screen_select_ctrl: directed vectors push expected outputs, a monitor pops and compares.
module tb_screen_select_ctrl;

    logic        clk;
    logic        rst;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        ButtonLeft;
    logic        ButtonRight;
    logic [47:0] rgb_in;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;
    logic [11:0] rgb;
    logic [1:0]  screen;
    logic        changed;

    typedef struct {
        logic [1:0]  scr;
        logic        ch;
        logic [11:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    exp_t        expQ[$];
    logic [11:0] rgbTable [4];
    int          vectors;
    int          miscompares;

    screen_select_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .xpos        (xpos),
        .ypos        (ypos),
        .ButtonLeft  (ButtonLeft),
        .ButtonRight (ButtonRight),
        .rgb_in      (rgb_in),
        .xpos_out    (xpos_out),
        .ypos_out    (ypos_out),
        .rgb         (rgb),
        .screen      (screen),
        .changed     (changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue what the outputs must be right after the next edge.
    task automatic applyStimulus(input logic r, input logic bl, input logic br,
                                 input logic [11:0] x, input logic [11:0] y,
                                 input logic [1:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        rst         = r;
        ButtonLeft  = bl;
        ButtonRight = br;
        xpos        = x;
        ypos        = y;
        e.scr = es;
        e.ch  = ec;
        e.rgb = rgbTable[es];
        e.x   = x;
        e.y   = y;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] es);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, es, 1'b0);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (screen !== e.scr || changed !== e.ch || rgb !== e.rgb ||
            xpos_out !== e.x || ypos_out !== e.y) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got screen=%0d changed=%0b rgb=%h xo=%0d yo=%0d, want screen=%0d changed=%0b rgb=%h xo=%0d yo=%0d",
                     vectors, screen, changed, rgb, xpos_out, ypos_out,
                     e.scr, e.ch, e.rgb, e.x, e.y);
        end
    endtask

    // Monitor: one expected entry is consumed per clock, just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rgbTable[0] = 12'h1A1;
        rgbTable[1] = 12'h2B2;
        rgbTable[2] = 12'h3C3;
        rgbTable[3] = 12'h4D4;
        rgb_in      = {12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};
        rst         = 1'b1;
        ButtonLeft  = 1'b0;
        ButtonRight = 1'b0;
        xpos        = '0;
        ypos        = '0;

        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0,   12'd0,   2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0,   12'd0,   2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd530, 12'd335, 2'd0, 1'b0);

        // Misses just outside the screen0 hotspot.
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd561, 12'd335, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd561, 12'd335, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd530, 12'd351, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd530, 12'd351, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd530, 12'd319, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd530, 12'd319, 2'd0, 1'b0);

        // Hit: 0 -> 1, then a click 5 cycles later is inside holdoff.
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd530, 12'd335, 2'd1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 12'd1000, 12'd20, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd1000, 12'd20, 2'd1, 1'b0);
        repeat (11) applyStimulus(1'b0, 1'b0, 1'b0, 12'd1000, 12'd20, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd1000, 12'd20, 2'd0, 1'b1);

        // Button held through the whole holdoff while sitting on the screen0 hotspot.
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 12'd530, 12'd335, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd530, 12'd335, 2'd0, 1'b0);

        // Upper corner hits; click 16 cycles later is still held off, 18 cycles later accepted.
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd560, 12'd350, 2'd1, 1'b1);
        repeat (15) applyStimulus(1'b0, 1'b0, 1'b0, 12'd1000, 12'd20, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd1000, 12'd20, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd1000, 12'd20, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd1000, 12'd20, 2'd0, 1'b1);

        // Lower corner hits after exactly 17 cycles.
        idle(16, 2'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd500, 12'd320, 2'd1, 1'b1);

        // Reset mid-holdoff, then a click right after release.
        idle(2, 2'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd7, 12'd9, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd8, 12'd9, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd530, 12'd335, 2'd1, 1'b1);
        idle(17, 2'd1);

        // Right-button edge after holdoff: back to screen0 only when the feature is built in.
`ifdef SCREEN_CTRL_BACK_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 2'd0, 1'b1);
        idle(2, 2'd0);
`else
        applyStimulus(1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 2'd1, 1'b0);
        idle(2, 2'd1);
`endif

        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expected entries left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
